// File: rtl/sliced_adder_if.sv
// Operand/result handshake bundle for sliced_adder.
// master drives operands and out_ready; slave is the adder.
interface sliced_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] Y;
   logic             Cin;
   logic             SUB;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] G;
   logic             Cout;
   logic             V;
   logic             N;
   logic             Z;

   modport master (
      output in_valid, A, Y, Cin, SUB, out_ready,
      input  in_ready, out_valid, G, Cout, V, N, Z
   );

   modport slave (
      input  in_valid, A, Y, Cin, SUB, out_ready,
      output in_ready, out_valid, G, Cout, V, N, Z
   );
endinterface

// File: rtl/sliced_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, SLICE bits per clock, with C/V/N/Z flags.
// Latency: result valid NSL edges after accept. Backpressure: one op in flight, result held until out_ready.
// Optional saturation on signed overflow: define SLICED_ADDER_SAT_EN.
module sliced_adder #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   sliced_adder_if.slave bus
);
   localparam int NSL = WIDTH / SLICE;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSL - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt;
   logic [WIDTH-1:0]       a_q, y_q, acc;
   logic                   carry;
   logic [WIDTH-1:0]       g_q;
   logic                   cout_q, v_q, n_q, z_q;

   logic [SLICE:0]         slice_sum;
   logic [WIDTH+SLICE-1:0] acc_cat;
   logic [WIDTH-1:0]       res, g_fin;
   logic                   last, v_fin;

   // Operands shift down one slice per cycle, so slice k is always at the bottom;
   // the accumulator fills from the top and is fully aligned after NSL shifts.
   always_comb begin
      slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, y_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
      acc_cat   = {slice_sum[SLICE-1:0], acc};
      res       = acc_cat[WIDTH+SLICE-1:SLICE];
      last      = (cnt == LAST);
      v_fin     = a_q[SLICE-1] ^ y_q[SLICE-1] ^ slice_sum[SLICE-1] ^ slice_sum[SLICE];
      g_fin     = res;
`ifdef SLICED_ADDER_SAT_EN
      if (v_fin) begin
         g_fin = a_q[SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         a_q    <= '0;
         y_q    <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         g_q    <= '0;
         cout_q <= 1'b0;
         v_q    <= 1'b0;
         n_q    <= 1'b0;
         z_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.A;
                  y_q   <= bus.SUB ? ~bus.Y : bus.Y;
                  carry <= bus.Cin;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_q   <= a_q >> SLICE;
               y_q   <= y_q >> SLICE;
               acc   <= res;
               carry <= slice_sum[SLICE];
               if (last) begin
                  g_q    <= g_fin;
                  cout_q <= slice_sum[SLICE];
                  v_q    <= v_fin;
                  n_q    <= g_fin[WIDTH-1];
                  z_q    <= (g_fin == '0);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.G    = g_q;
   assign bus.Cout = cout_q;
   assign bus.V    = v_q;
   assign bus.N    = n_q;
   assign bus.Z    = z_q;
endmodule

// File: tb/tb_sliced_adder.sv
// Randomized and directed bench for sliced_adder against an arithmetic reference model.
module tb_sliced_adder;
   localparam int WIDTH = 32;
   localparam int SLICE = 8;
   localparam int NSL   = WIDTH / SLICE;

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic             c;
      logic             v;
      logic             n;
      logic             z;
   } res_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   sliced_adder_if #(.WIDTH(WIDTH)) bus ();

   sliced_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] y,
                                  input logic cin, input logic sub);
      res_t             r;
      logic [WIDTH-1:0] ye;
      logic [WIDTH:0]   s;
      ye  = sub ? ~y : y;
      s   = {1'b0, a} + {1'b0, ye} + (WIDTH+1)'(cin);
      r.g = s[WIDTH-1:0];
      r.c = s[WIDTH];
      r.v = (a[WIDTH-1] == ye[WIDTH-1]) && (r.g[WIDTH-1] != a[WIDTH-1]);
`ifdef SLICED_ADDER_SAT_EN
      if (r.v) r.g = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      r.n = r.g[WIDTH-1];
      r.z = (r.g == '0);
      return r;
   endfunction

   task automatic check_result(input string tag, input res_t e);
      check({tag, ".G"},    64'(bus.G),    64'(e.g));
      check({tag, ".Cout"}, 64'(bus.Cout), 64'(e.c));
      check({tag, ".V"},    64'(bus.V),    64'(e.v));
      check({tag, ".N"},    64'(bus.N),    64'(e.n));
      check({tag, ".Z"},    64'(bus.Z),    64'(e.z));
   endtask

   // One full transaction; hold = cycles out_ready stays low after out_valid
   // while junk operands are offered on the input side.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] y,
                         input logic cin, input logic sub, input int hold);
      res_t             e;
      logic [WIDTH-1:0] g_prev;
      int               n;
      e = model(a, y, cin, sub);
      @(negedge clk);
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
      bus.A        = a;
      bus.Y        = y;
      bus.Cin      = cin;
      bus.SUB      = sub;
      bus.in_valid = 1'b1;
      g_prev       = bus.G;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         check({tag, ".G_hidden"}, 64'(bus.G), 64'(g_prev));
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, ".latency"}, 64'(n), 64'(NSL));
      check_result(tag, e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.in_valid  = ~bus.in_valid;
         bus.A         = $urandom;
         bus.Y         = $urandom;
         bus.Cin       = 1'($urandom);
         bus.SUB       = 1'($urandom);
         @(posedge clk);
         #1;
         check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'(1));
         check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'(0));
         check_result({tag, ".hold"}, e);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, ".released_valid"}, 64'(bus.out_valid), 64'(0));
      check({tag, ".released_idle"}, 64'(bus.in_ready), 64'(1));
      check({tag, ".kept_G"}, 64'(bus.G), 64'(e.g));
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.Y         = '0;
      bus.Cin       = 1'b0;
      bus.SUB       = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      check("rst.G", 64'(bus.G), 64'(0));
      check("rst.flags", 64'({bus.Cout, bus.V, bus.N, bus.Z}), 64'(0));
      check("rst.out_valid", 64'(bus.out_valid), 64'(0));
      check("rst.in_ready", 64'(bus.in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;

      run_op("zero",    32'h00000000, 32'h00000000, 1'b0, 1'b0, 0);
      run_op("ripple",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
      run_op("ovf",     32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 0);
      run_op("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 0);
      run_op("sub_pos", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 0);
      run_op("neg_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
      run_op("bp",      32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 6);
      run_op("after_bp", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 0);

      // Asynchronous reset two RUN cycles into an operation.
      @(negedge clk);
      bus.A        = 32'hDEADBEEF;
      bus.Y        = 32'h01010101;
      bus.Cin      = 1'b0;
      bus.SUB      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst.G", 64'(bus.G), 64'(0));
      check("arst.flags", 64'({bus.Cout, bus.V, bus.N, bus.Z}), 64'(0));
      check("arst.out_valid", 64'(bus.out_valid), 64'(0));
      check("arst.in_ready", 64'(bus.in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] ra, ry;
         ra = $urandom;
         ry = $urandom;
         if (i % 8 == 0) ra = {1'b0, {(WIDTH-1){1'b1}}};
         if (i % 8 == 1) ry = {1'b1, {(WIDTH-1){1'b0}}};
         run_op("rand", ra, ry, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sliced_adder.md
Name: sliced_adder

Overview:
- Parametrised, multi-cycle successor to the 32-bit parallel adder in the ALU arithmetic unit.
- Computes G = A + Yeff + Cin over WIDTH bits, SLICE bits per clock, so wide adds close timing at high clock rates.
- Adds a subtract mode, status flags (C, V, N, Z) and valid/ready handshakes on both sides.
- Sits between operand registers and the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE, at least 2.
- SLICE, 8, bits added per cycle; NSL = WIDTH/SLICE cycles per add.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- Y  input  WIDTH  operand Y
- Cin  input  1  carry in
- SUB  input  1  1: Yeff = ~Y; 0: Yeff = Y
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- G  output  WIDTH  sum
- Cout  output  1  carry out of bit WIDTH-1
- V  output  1  signed overflow
- N  output  1  G[WIDTH-1]
- Z  output  1  G == 0

Behaviour:
- Reset (rst_n low, async): state IDLE; slice counter 0; G, Cout, V, N, Z and out_valid all 0. in_ready = 1, since it is decoded from IDLE.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: latch A, Yeff (SUB applied at capture), Cin and the running carry; clear the counter; go to RUN.
  - SUB is not auto-applied to carry. Callers pass Cin = 1 for two's-complement subtract.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle adds slice k (bits k*SLICE .. k*SLICE+SLICE-1) of A and Yeff plus the running carry.
  - The slice sum is stored in an internal accumulator; the slice carry out becomes the next running carry.
  - After slice NSL-1: go to DONE.
- Latency:
  - out_valid rises exactly NSL edges after the accept edge (NSL = 4 at defaults).
  - NSL = 1 is legal: one RUN cycle.
- Entering DONE:
  - G is loaded from the accumulator; Cout = final carry.
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - N = G[WIDTH-1]; Z = (G == 0); out_valid = 1.
- DONE:
  - out_valid, G and all flags are held stable until an edge with out_ready = 1.
  - On that edge: out_valid -> 0 and the FSM goes to IDLE. G and flags keep their last values.
  - in_ready = 0 in DONE, so no overlap with the next operation. Throughput is 1 result per NSL+2 cycles with out_ready held high.
- G and flags change only on the edge where out_valid rises; the partial accumulator is never visible on outputs.
- Arithmetic is modulo 2^WIDTH, with no sign extension.
- Simultaneous events: in_valid during RUN or DONE is ignored, and the operand is not queued.
- Reset mid-operation: the partial result is discarded and outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: SLICED_ADDER_SAT_EN.
- Defined:
  - When V = 1, G saturates: to 0 followed by WIDTH-1 ones (max positive) if A[WIDTH-1] = 0, else to 1 followed by WIDTH-1 zeros (min negative).
  - N and Z are computed from the saturated G.
  - V still reports that overflow occurred; Cout is unchanged.
- Undefined: G wraps modulo 2^WIDTH; no saturation logic is compiled.

Test Plan (defaults WIDTH=32, SLICE=8):
- A=00000000, Y=00000000, Cin=0, SUB=0 -> out_valid exactly 4 edges after accept; G=00000000, Cout=0, V=0, N=0, Z=1.
- A=FFFFFFFF, Y=00000001, Cin=0 -> G=00000000, Cout=1, V=0, Z=1; confirms carry ripples across all 4 slices.
- A=7FFFFFFF, Y=00000001, Cin=1 -> G=80000001, V=1, N=1, Cout=0. With SLICED_ADDER_SAT_EN: G=7FFFFFFF, N=0, V=1.
- A=00000005, Y=00000007, SUB=1, Cin=1 -> G=FFFFFFFE, Cout=0, N=1, V=0. Then A=7, Y=5 -> G=00000002, Cout=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, toggling in_valid with new operands -> out_valid, G and flags stable; in_ready=0 throughout. Release out_ready -> IDLE next edge; the next add gives its correct result.
- Assert rst_n=0 asynchronously after 2 RUN cycles -> all outputs 0 and in_ready=1 without a clock edge. After release, a new add (A=00000001, Y=00000001) -> G=00000002 after 4 cycles.
